// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one ripple-carry adder among NREQ requesters, one add in flight.
// Optional build macro ADDER_ARB_SAT_EN: saturate sum to all-ones when the carry-out is set.

module adder_nbit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);
  logic [WIDTH:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    assign o_sum[gi]       = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
    assign w_carry[gi + 1] = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
  end

  assign o_cout = w_carry[WIDTH];
endmodule

module adder_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     a_in,
  input  logic [NREQ*WIDTH-1:0]     b_in,
  input  logic [NREQ-1:0]           cin,
  output logic [NREQ-1:0]           grant,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          sum,
  output logic                      overflow,
  output logic [$clog2(NREQ)-1:0]   out_id
);
  localparam int IW = $clog2(NREQ);
  localparam logic [IW:0]   NREQ_W  = (IW + 1)'(NREQ);
  localparam logic [IW-1:0] LAST_ID = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [NREQ-1:0]   r_grant;
  logic              r_valid;
  logic [WIDTH-1:0]  r_sum;
  logic              r_ovf;
  logic [IW-1:0]     r_id;
  logic [IW-1:0]     r_rr_ptr;
  logic [IW-1:0]     r_owner;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_cin;

  logic [2*NREQ-1:0] w_req2;
  logic [NREQ-1:0]   w_rot;
  logic              w_found;
  logic [IW-1:0]     w_off;
  logic [IW:0]       w_sum_idx;
  logic [IW-1:0]     w_winner;
  logic [IW-1:0]     w_ptr_next;
  logic [NREQ-1:0]   w_grant_onehot;
  logic [WIDTH-1:0]  w_add_sum;
  logic              w_cout;
  logic [WIDTH-1:0]  w_sum_final;

  // Rotate requests so bit 0 is the requester at rr_ptr; the lowest set bit wins.
  assign w_req2  = {req, req};
  assign w_rot   = NREQ'(w_req2 >> r_rr_ptr);
  assign w_found = |w_rot;

  always_comb begin
    w_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = IW'(k);
      end
    end
  end

  assign w_sum_idx      = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_winner       = (w_sum_idx >= NREQ_W) ? IW'(w_sum_idx - NREQ_W) : IW'(w_sum_idx);
  assign w_ptr_next     = (w_winner == LAST_ID) ? '0 : w_winner + 1'b1;
  assign w_grant_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;

  adder_nbit #(.WIDTH(WIDTH)) u_adder (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_cin  (r_cin),
    .o_sum  (w_add_sum),
    .o_cout (w_cout)
  );

`ifdef ADDER_ARB_SAT_EN
  assign w_sum_final = w_cout ? {WIDTH{1'b1}} : w_add_sum;
`else
  assign w_sum_final = w_add_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_valid  <= 1'b0;
      r_sum    <= '0;
      r_ovf    <= 1'b0;
      r_id     <= '0;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cin    <= 1'b0;
    end else begin
      r_grant <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_a      <= a_in[w_winner*WIDTH +: WIDTH];
            r_b      <= b_in[w_winner*WIDTH +: WIDTH];
            r_cin    <= cin[w_winner];
            r_owner  <= w_winner;
            r_grant  <= w_grant_onehot;
            r_rr_ptr <= w_ptr_next;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_sum   <= w_sum_final;
          r_ovf   <= w_cout;
          r_id    <= r_owner;
          r_valid <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          // Result registers keep their values after hand-off; only valid drops.
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant     = r_grant;
  assign out_valid = r_valid;
  assign sum       = r_sum;
  assign overflow  = r_ovf;
  assign out_id    = r_id;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: table of single-requester adds plus
// hand-written sequences for round-robin order, back-pressure and mid-operation reset.

module tb_adder_share_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
`ifdef ADDER_ARB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [NREQ-1:0]       cin;
  logic [NREQ-1:0]       grant;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      sum;
  logic                  overflow;
  logic [1:0]            out_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] raw_sum;
    logic       ovf;
  } vec_t;

  vec_t vecs[8];

  adder_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin       (cin),
    .grant     (grant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .overflow  (overflow),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic load(input int id, input logic [7:0] a, input logic [7:0] b, input logic c);
    a_in[id*WIDTH +: WIDTH] = a;
    b_in[id*WIDTH +: WIDTH] = b;
    cin[id] = c;
  endtask

  function automatic logic [7:0] exp_sum(input logic [7:0] raw, input logic ovf);
    return (SAT && ovf) ? 8'hFF : raw;
  endfunction

  logic [3:0] rr_grant[5];
  logic [7:0] rr_sum[4];
  logic [3:0] one_hot;

  initial begin
    vecs[0] = '{2, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[1] = '{1, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1};
    vecs[2] = '{0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{3, 8'h7F, 8'h80, 1'b0, 8'hFF, 1'b0};
    vecs[4] = '{3, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{1, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{2, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    rr_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_sum   = '{8'h11, 8'h23, 8'h33, 8'h45};

    // Background operands in every slot so a wrong slot selection shows up.
    a_in = 32'hA5C3_E1B7;
    b_in = 32'h5A3C_1E7B;
    cin  = 4'b0000;
    out_ready = 1'b1;

    // Reset with all requesters asserting: nothing may be granted.
    rst = 1'b1;
    req = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_grant", grant, 4'b0000);
      check("rst_valid", out_valid, 1'b0);
      check("rst_sum", sum, 8'h00);
    end
    check("rst_ovf", overflow, 1'b0);
    check("rst_id", out_id, 2'd0);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      one_hot = 4'b0001 << vecs[v].id;
      req = one_hot;
      load(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].cin);
      tick();
      check("vec_grant", grant, one_hot);
      check("vec_valid_early", out_valid, 1'b0);
      req = 4'b0000;
      tick();
      check("vec_grant_clear", grant, 4'b0000);
      check("vec_valid", out_valid, 1'b1);
      check("vec_sum", sum, exp_sum(vecs[v].raw_sum, vecs[v].ovf));
      check("vec_ovf", overflow, vecs[v].ovf);
      check("vec_id", out_id, vecs[v].id);
      $display("vec %0d: id=%0d a=%02h b=%02h cin=%0d -> sum=%02h ovf=%0d",
               v, vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].cin, sum, overflow);
      tick();
      check("vec_valid_drop", out_valid, 1'b0);
      check("vec_sum_hold", sum, exp_sum(vecs[v].raw_sum, vecs[v].ovf));
    end

    // Round-robin with all requesters held: pointer restarts at 0 after reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      load(i, 8'(8'h10 * (i + 1)), 8'(i + 1), i[0]);
    end
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      check("rr_grant", grant, rr_grant[g]);
      tick();
      check("rr_valid", out_valid, 1'b1);
      check("rr_id", out_id, g % NREQ);
      check("rr_sum", sum, rr_sum[g % NREQ]);
      $display("rr %0d: grant=%04b id=%0d sum=%02h", g, rr_grant[g], out_id, sum);
      tick();
      check("rr_idle", out_valid, 1'b0);
    end

    // Back-pressure: result held, no grant while the consumer stalls.
    out_ready = 1'b0;
    tick();
    check("bp_grant", grant, 4'b0010);
    tick();
    check("bp_valid", out_valid, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_sum", sum, 8'h23);
      check("bp_hold_id", out_id, 2'd1);
      check("bp_no_grant", grant, 4'b0000);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_release_grant", grant, 4'b0000);
    tick();
    check("bp_next_grant", grant, 4'b0100);
    $display("backpressure: held sum=23 id=1, next grant=%04b", grant);

    // Reset while in CALC: pending add discarded, pointer back to 0.
    rst = 1'b1;
    tick();
    check("rstc_valid", out_valid, 1'b0);
    check("rstc_grant", grant, 4'b0000);
    check("rstc_sum", sum, 8'h00);
    rst = 1'b0;
    req = 4'b1010;
    tick();
    check("rstc_first_grant", grant, 4'b0010);
    req = 4'b1000;
    tick();
    check("rstc_valid2", out_valid, 1'b1);
    check("rstc_id", out_id, 2'd1);
    check("rstc_sum2", sum, 8'h23);
    $display("reset-in-calc: first grant after reset to id=%0d", out_id);
    tick();
    tick();
    check("rstc_second_grant", grant, 4'b1000);
    req = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
